ps2_key_encoder: RTL and testbench

PS2_KEY_ENCODER -- requirements
Module: ps2_key_encoder

---
 rtl/ps2_key_encoder_pkg.sv | 36 +++
 rtl/ps2_key_encoder_if.sv | 15 +
 rtl/key_evt_fifo.sv | 53 +++++
 rtl/ps2_key_encoder.sv | 109 ++++++++++
 tb/tb_ps2_key_encoder.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_encoder_pkg.sv
// Shared definitions for the PS/2 key encoder: transmit FSM states, event bit
// positions and the per-index {extended, scan code} table.
package ps2_key_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_WAIT = 2'd2
  } tx_state_e;

  localparam int EVT_W       = 11;
  localparam int EVT_TOGGLE  = 10;
  localparam int EVT_PRESSED = 9;
  localparam int EVT_EXT     = 8;
  localparam int FIFO_W      = 10;

  function automatic logic [8:0] key_code(input logic [3:0] idx);
    case (idx)
      4'd0:    key_code = 9'h06B;
      4'd1:    key_code = 9'h074;
      4'd2:    key_code = 9'h029;
      4'd3:    key_code = 9'h005;
      4'd4:    key_code = 9'h006;
      4'd5:    key_code = 9'h016;
      4'd6:    key_code = 9'h01E;
      4'd7:    key_code = 9'h02E;
      4'd8:    key_code = 9'h036;
      4'd9:    key_code = 9'h023;
      4'd10:   key_code = 9'h034;
      4'd11:   key_code = 9'h01C;
      4'd12:   key_code = 9'h014;
      default: key_code = 9'h000;
    endcase
  endfunction

endpackage

// File: rtl/ps2_key_encoder_if.sv
// Bundle of the encoder's key inputs and event outputs, as seen by a host
// (drives the virtual keys) and by the encoder side.
interface ps2_key_encoder_if #(
  parameter int NKEYS = 13
);
  import ps2_key_encoder_pkg::*;

  logic [NKEYS-1:0] keys_in;
  logic [EVT_W-1:0] ps2_key;
  logic             busy;
  logic             pending;

  modport master (output keys_in, input ps2_key, busy, pending);
  modport slave  (input keys_in, output ps2_key, busy, pending);
endinterface

// File: rtl/key_evt_fifo.sv
// Small show-ahead event FIFO; pointers carry one extra bit so full and empty
// are distinguishable when the index bits match.
module key_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Full is judged on the pre-edge pointers, so a pop never makes room for
  // a push in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ps2_key_encoder.sv
// Turns virtual key levels into PS/2-style toggle events: a priority scan
// queues level changes, and a paced FSM publishes them GAP cycles apart.
module ps2_key_encoder
  import ps2_key_encoder_pkg::*;
#(
  parameter int NKEYS = 13,
  parameter int GAP   = 48,
  parameter int DEPTH = 8
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [NKEYS-1:0] keys_in,
  output logic [EVT_W-1:0] ps2_key,
  output logic             busy,
  output logic             pending
);
  logic [NKEYS-1:0]  reported_q, reported_d;
  logic [NKEYS-1:0]  diff;
  logic [3:0]        sel_idx;
  logic              sel_valid;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;
  tx_state_e         state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [EVT_W-1:0]  ps2_key_q, ps2_key_d;

  // Scanning downwards leaves the lowest differing index selected.
  always_comb begin
    diff      = keys_in ^ reported_q;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (diff[i]) begin
        sel_valid = 1'b1;
        sel_idx   = 4'(i);
      end
    end
  end

  always_comb begin
    fifo_wdata              = '0;
    fifo_wdata[EVT_PRESSED] = keys_in[sel_idx];
    fifo_wdata[EVT_EXT:0]   = key_code(sel_idx);
    fifo_push               = sel_valid && !fifo_full;
    reported_d              = reported_q;
    if (fifo_push) reported_d[sel_idx] = keys_in[sel_idx];
  end

  key_evt_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // WAIT lasts GAP-2 cycles (at least one), so with IDLE and EMIT the
  // update-to-update distance is GAP for any GAP >= 3.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ps2_key_d = ps2_key_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_EMIT;
      ST_EMIT: begin
        ps2_key_d[EVT_TOGGLE]    = ~ps2_key_q[EVT_TOGGLE];
        ps2_key_d[EVT_PRESSED:0] = fifo_rdata;
        fifo_pop                 = 1'b1;
        cnt_d                    = 8'(GAP - 2);
        state_d                  = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q <= 8'd1) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ps2_key_q  <= '0;
      reported_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ps2_key_q  <= ps2_key_d;
      reported_q <= reported_d;
    end
  end

  assign ps2_key = ps2_key_q;
  assign busy    = !fifo_empty || (state_q != ST_IDLE);
  assign pending = |diff;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Scoreboard bench: a transaction-level model predicts each ps2_key update
// (value and edge), a negedge monitor pops and compares.
module tb_ps2_key_encoder;
  localparam int NK    = 13;
  localparam int GAP   = 4;
  localparam int DEPTH = 2;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  ps2_key_encoder_if #(.NKEYS(NK)) bus ();

  ps2_key_encoder #(.NKEYS(NK), .GAP(GAP), .DEPTH(DEPTH)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .keys_in (bus.keys_in),
    .ps2_key (bus.ps2_key),
    .busy    (bus.busy),
    .pending (bus.pending)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model state
  int         code_tbl [NK] = '{'h06B, 'h074, 'h029, 'h005, 'h006, 'h016, 'h01E,
                                'h02E, 'h036, 'h023, 'h034, 'h01C, 'h014};
  typedef struct {
    logic [10:0] val;
    int          edge_no;
  } exp_t;
  exp_t       exp_q [$];
  bit         rep [NK];
  logic [9:0] mq [$];
  bit         tgl;
  int         cyc        = 0;
  int         sched_edge = -1;
  int         free_edge  = 0;
  int         last_upd   = -1000;
  int         m_sel;
  bit         m_full;
  logic [8:0] m_code;

  always @(posedge clk_sys) begin
    cyc++;
    if (!reset_n) begin
      foreach (rep[i]) rep[i] = 1'b0;
      mq.delete();
      exp_q.delete();
      tgl        = 1'b0;
      sched_edge = -1;
      free_edge  = 0;
      last_upd   = -1000;
    end else begin
      m_full = (mq.size() >= DEPTH);
      m_sel  = -1;
      for (int i = 0; i < NK; i++)
        if (m_sel < 0 && bus.keys_in[i] != rep[i]) m_sel = i;
      if (m_sel >= 0 && !m_full) begin
        m_code = code_tbl[m_sel][8:0];
        mq.push_back({bus.keys_in[m_sel], m_code});
        rep[m_sel] = bus.keys_in[m_sel];
      end
      if (sched_edge == cyc) begin
        tgl = ~tgl;
        exp_q.push_back('{val: {tgl, mq.pop_front()}, edge_no: cyc});
        sched_edge = -1;
        last_upd   = cyc;
      end
      // Next update two edges after the head is visible, never closer than GAP.
      if (sched_edge < 0 && mq.size() > 0 && cyc >= free_edge - 2) begin
        sched_edge = cyc + 2;
        free_edge  = cyc + 2 + GAP;
      end
    end
  end

  // Monitor
  logic [10:0] prev_key = '0;
  exp_t        e;
  bit          exp_busy, exp_pend;

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      chk("reset_ps2_key", 32'(bus.ps2_key), 32'h0);
      chk("reset_busy", 32'(bus.busy), 32'h0);
      exp_q.delete();
      prev_key = '0;
    end else begin
      exp_busy = (mq.size() != 0) || (sched_edge >= 0) || (cyc < last_upd + GAP - 2);
      exp_pend = 1'b0;
      for (int i = 0; i < NK; i++) if (bus.keys_in[i] != rep[i]) exp_pend = 1'b1;
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("pending", 32'(bus.pending), 32'(exp_pend));
      while (exp_q.size() > 0 && exp_q[0].edge_no < cyc) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_event actual=none required=0x%03h due_edge=%0d", e.val, e.edge_no);
      end
      if (bus.ps2_key !== prev_key) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event actual=0x%03h required=no_change edge=%0d", bus.ps2_key, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("event_value", 32'(bus.ps2_key), 32'(e.val));
          chk("event_edge", 32'(cyc), 32'(e.edge_no));
          $display("evt edge=%0d ps2_key=0x%03h expected=0x%03h", cyc, bus.ps2_key, e.val);
        end
        prev_key = bus.ps2_key;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #3;
  endtask

  task automatic wait_event(input string name);
    logic [10:0] p;
    int          n;
    p = bus.ps2_key;
    n = 0;
    while (bus.ps2_key === p && n < 100) begin
      wait_cyc(1);
      n++;
    end
    chk(name, 32'(n < 100), 32'h1);
  endtask

  initial begin
    int n;
    bus.keys_in = '0;
    reset_n     = 1'b0;
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(20);
    chk("idle_ps2_key", 32'(bus.ps2_key), 32'h0);

    // Single key press and release
    bus.keys_in[2] = 1'b1;
    wait_cyc(10);
    bus.keys_in[2] = 1'b0;
    wait_cyc(15);
    bus.keys_in[2] = 1'b1;
    wait_cyc(1);
    bus.keys_in[2] = 1'b0;
    wait_cyc(20);

    // Three simultaneous presses
    bus.keys_in[2:0] = 3'b111;
    wait_cyc(25);
    bus.keys_in = '0;
    wait_cyc(25);

    // One-cycle pulse on key 5 while the FIFO is full, then a held press
    bus.keys_in[3:0] = 4'hF;
    wait_cyc(1);
    bus.keys_in[5] = 1'b1;
    wait_cyc(1);
    bus.keys_in[5] = 1'b0;
    wait_cyc(30);
    bus.keys_in[5] = 1'b1;
    n = 0;
    while (bus.pending && n < 200) begin
      wait_cyc(1);
      n++;
    end
    chk("key5_accepted", 32'(n < 200), 32'h1);
    wait_cyc(20);
    bus.keys_in = '0;
    wait_cyc(40);

    // Reset during WAIT with events still queued
    bus.keys_in[9:6] = 4'hF;
    wait_event("wait_first_evt");
    wait_cyc(1);
    reset_n     = 1'b0;
    bus.keys_in = '0;
    #1;
    chk("async_reset_key", 32'(bus.ps2_key), 32'h0);
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(30);

    // Key held through reset
    reset_n        = 1'b0;
    bus.keys_in[0] = 1'b1;
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(10);
    chk("held_through_reset", 32'(bus.ps2_key), 32'h66B);
    bus.keys_in = '0;
    wait_cyc(20);

    // Randomised key activity with occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(39) == 0) bus.keys_in[i] = ~bus.keys_in[i];
      if ($urandom_range(999) == 0) begin
        reset_n = 1'b0;
        wait_cyc(2);
        reset_n = 1'b1;
      end
      wait_cyc(1);
    end

    bus.keys_in = '0;
    n = 0;
    while ((bus.busy || bus.pending) && n < 500) begin
      wait_cyc(1);
      n++;
    end
    chk("drained", 32'(n < 500), 32'h1);
    wait_cyc(2);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
